// File: rtl/sprite_link_pkg.sv
// Shared definitions for the sprite byte-strobe link.
// Used by both the transmitter and the receiving sprite queue.
package sprite_link_pkg;

  localparam int SPRITE_FRAME_BYTES = 6;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } sprite_rec_t;

  // Wire order of a frame: id, x hi, x lo, y hi, y lo, scale.
  function automatic logic [7:0] sprite_byte(input sprite_rec_t rec, input logic [2:0] idx);
    case (idx)
      3'd0:    return rec.id;
      3'd1:    return rec.x[15:8];
      3'd2:    return rec.x[7:0];
      3'd3:    return rec.y[15:8];
      3'd4:    return rec.y[7:0];
      3'd5:    return rec.scale;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/link_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 therefore yields a phase lasting exactly N cycles.
module link_phase_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Count register: load wins over decrement, holds at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/sprite_frame_tx.sv
// Sprite record serializer: one record per handshake becomes an optional
// resync strobe followed by a 6-byte frame on the data_clk/enqueue link.
module sprite_frame_tx
  import sprite_link_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STROBE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  sprite_id,
  input  logic [15:0] sprite_x,
  input  logic [15:0] sprite_y,
  input  logic [7:0]  sprite_scale,
  output logic        data_clk,
  output logic        enqueue_en,
  output logic [7:0]  enqueue_data,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int MAX_HG  = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > 1) ? MAX_HG : 1;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [2:0]    LAST_IDX  = 3'(SPRITE_FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_LO,
    ST_SYNC_HI,
    ST_BYTE_LO,
    ST_BYTE_HI,
    ST_GAP
  } tx_state_t;

  tx_state_t   state_r, next_state_s;
  logic [2:0]  byte_idx_r, next_idx_s;
  sprite_rec_t rec_r, rec_in_s, rec_next_s;
  logic        accept_s, load_s, timer_done_s, frame_done_s;
  logic [CW-1:0] load_val_s;
  logic        nxt_dclk_s, nxt_en_s;
  logic [7:0]  nxt_data_s;
  logic        data_clk_r, enqueue_en_r, in_ready_r, busy_r;
  logic [7:0]  enqueue_data_r;
  logic [15:0] frames_sent_r;

  assign rec_in_s   = '{id: sprite_id, x: sprite_x, y: sprite_y, scale: sprite_scale};
  assign accept_s   = in_valid && in_ready_r;
  assign rec_next_s = accept_s ? rec_in_s : rec_r;

  link_phase_timer #(.W(CW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .done     (timer_done_s)
  );

  // Next-state, byte index and timer reload decisions.
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = byte_idx_r;
    load_s       = 1'b0;
    load_val_s   = HALF_LOAD;
    frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = (SYNC_STROBE != 0) ? ST_SYNC_LO : ST_BYTE_LO;
          next_idx_s   = 3'd0;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SYNC_LO: begin
        if (timer_done_s) begin
          next_state_s = ST_SYNC_HI;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_SYNC_LO;
        end
      end
      ST_SYNC_HI: begin
        if (timer_done_s) begin
          next_state_s = ST_BYTE_LO;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_SYNC_HI;
        end
      end
      ST_BYTE_LO: begin
        if (timer_done_s) begin
          next_state_s = ST_BYTE_HI;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_BYTE_LO;
        end
      end
      ST_BYTE_HI: begin
        if (!timer_done_s) begin
          next_state_s = ST_BYTE_HI;
        end else if (byte_idx_r < LAST_IDX) begin
          next_state_s = ST_BYTE_LO;
          next_idx_s   = byte_idx_r + 3'd1;
          load_s       = 1'b1;
        end else begin
          // A zero-length gap drops straight back to IDLE.
          frame_done_s = 1'b1;
          if (GAP_CYCLES > 0) begin
            next_state_s = ST_GAP;
            load_s       = 1'b1;
            load_val_s   = GAP_LOAD;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (timer_done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Link output values for the state being entered, so they can be registered.
  always_comb begin
    nxt_dclk_s = 1'b0;
    nxt_en_s   = 1'b0;
    nxt_data_s = 8'h00;
    case (next_state_s)
      ST_SYNC_LO: nxt_dclk_s = 1'b0;
      ST_SYNC_HI: nxt_dclk_s = 1'b1;
      ST_BYTE_LO: begin
        nxt_en_s   = 1'b1;
        nxt_data_s = sprite_byte(rec_next_s, next_idx_s);
      end
      ST_BYTE_HI: begin
        nxt_dclk_s = 1'b1;
        nxt_en_s   = 1'b1;
        nxt_data_s = sprite_byte(rec_next_s, next_idx_s);
      end
      ST_GAP:     nxt_data_s = sprite_byte(rec_next_s, next_idx_s);
      default:    nxt_data_s = 8'h00;
    endcase
  end

  // State, record latch, registered link outputs and frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      byte_idx_r     <= 3'd0;
      rec_r          <= '0;
      data_clk_r     <= 1'b0;
      enqueue_en_r   <= 1'b0;
      enqueue_data_r <= 8'h00;
      in_ready_r     <= 1'b0;
      busy_r         <= 1'b0;
      frames_sent_r  <= 16'd0;
    end else begin
      state_r        <= next_state_s;
      byte_idx_r     <= next_idx_s;
      rec_r          <= rec_next_s;
      data_clk_r     <= nxt_dclk_s;
      enqueue_en_r   <= nxt_en_s;
      enqueue_data_r <= nxt_data_s;
      in_ready_r     <= (next_state_s == ST_IDLE);
      busy_r         <= (next_state_s != ST_IDLE);
      frames_sent_r  <= frame_done_s ? (frames_sent_r + 16'd1) : frames_sent_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign data_clk     = data_clk_r;
  assign enqueue_en   = enqueue_en_r;
  assign enqueue_data = enqueue_data_r;
  assign frames_sent  = frames_sent_r;

endmodule

// File: doc/sprite_frame_tx.md
# sprite_frame_tx

Serializer that takes one sprite record (id, x, y, scale) per handshake and emits it as a 6-byte frame on the byte-strobe link: `data_clk`, `enqueue_en` and `enqueue_data`. It is the transmit end of the link that the sprite queue receives. It sits in the SPI driver area, where it drives FPGA-internal loopback, self-test and board-to-board bridging of sprite lists. Each frame is preceded by a resync strobe, so a receiver left mid-frame by an aborted transfer is realigned.

## Interface
- `HALF_PERIOD`, 4: `clock` cycles per `data_clk` phase (low and high). Legal range is ≥2.
- `GAP_CYCLES`, 2: idle cycles after each frame before `in_ready` reasserts. Legal range is ≥0.
- `SYNC_STROBE`, 1: 1 means emit a leading strobe with `enqueue_en`=0 before each frame; 0 means omit it.
- `clock` in 1: single clock. All logic is posedge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: record on `sprite_*` inputs is valid.
- `in_ready` out 1: block can accept a record. High only in IDLE.
- `sprite_id` in 8: sprite id.
- `sprite_x` in 16: x position.
- `sprite_y` in 16: y position.
- `sprite_scale` in 8: scale code.
- `data_clk` out 1: byte strobe. The receiver captures on its rising edge.
- `enqueue_en` out 1: frame-active qualifier, sampled at the `data_clk` rising edge.
- `enqueue_data` out 8: current byte.
- `busy` out 1: high whenever the state is not IDLE.
- `frames_sent` out 16: count of completed frames. Wraps at 65535→0.

## Operation
- **Acceptance:** a record is accepted on a cycle with `in_valid && in_ready`. All 48 record bits are latched, so the inputs may change afterwards.
- **Byte order:** id, x[15:8], x[7:0], y[15:8], y[7:0], scale (index 0..5).
- **States:**
  - IDLE → SYNC_LO on accept when SYNC_STROBE=1; otherwise IDLE → BYTE_LO.
  - SYNC_LO → SYNC_HI → BYTE_LO.
  - BYTE_LO → BYTE_HI.
  - BYTE_HI → BYTE_LO while byte index <5; at index 5 → GAP.
  - GAP → IDLE.
- **Phase timer:** every state except IDLE lasts exactly HALF_PERIOD cycles, except GAP, which lasts GAP_CYCLES. With GAP_CYCLES=0, GAP is skipped and BYTE_HI of byte 5 goes directly to IDLE.
- **Outputs in SYNC_LO / SYNC_HI:** `enqueue_en`=0, `enqueue_data`=0. `data_clk`=0 in SYNC_LO and 1 in SYNC_HI.
- **Outputs in BYTE_LO / BYTE_HI:** `enqueue_en`=1, `enqueue_data`=byte[index]. `data_clk`=0 in BYTE_LO and 1 in BYTE_HI.
- **Data stability:** `enqueue_data` and `enqueue_en` change only on entry to BYTE_LO or SYNC_LO. They are therefore stable for ≥HALF_PERIOD cycles on both sides of each `data_clk` rising edge.
- **Outputs in GAP / IDLE:** `data_clk`=0, `enqueue_en`=0. `enqueue_data` holds the last byte in GAP and is 0 in IDLE.
- **`frames_sent`:** increments by 1 on the cycle BYTE_HI of byte 5 ends.
- **Register outputs:** `data_clk`, `enqueue_en` and `enqueue_data` are registered, with no combinational path from the inputs.
- **`in_ready`:** decoded from state (state==IDLE); it does not depend on `in_valid`.

## Timing
- **Reset values:** all outputs are 0 (`data_clk`, `enqueue_en`, `enqueue_data`, `busy`, `frames_sent`, `in_ready`). State goes to IDLE.
- **After reset:** `in_ready`=1 on the first cycle after `reset` deasserts.
- **Start latency:** acceptance at cycle T puts the first driven state (SYNC_LO or BYTE_LO) on the outputs at T+1.
- **Frame length:** `in_ready` reasserts at T+1+2·HALF_PERIOD·(6+SYNC_STROBE)+GAP_CYCLES. With the defaults this is T+59.
- **Back-to-back:** a new record may be accepted on the very cycle `in_ready` reasserts.
- **Reset mid-frame:** the frame is abandoned with no partial count, and outputs return to reset values the next cycle. The leading sync strobe of the next frame clears the receiver byte index.
- **`in_valid` while busy:** ignored. It is neither latched nor lost-counted.
- **Counter width:** the phase counter is $clog2(max(HALF_PERIOD,GAP_CYCLES,1))+1 bits.

## Structure
- **Package `sprite_link_pkg`:** holds SPRITE_FRAME_BYTES=6, `sprite_rec_t` (packed struct: id[7:0], x[15:0], y[15:0], scale[7:0]), and the byte-select function mapping index to byte. The receiver side shares this package.
- **State enum:** local to the module.
- **Sub-module `link_phase_timer`:** loadable down-counter with a `done` pulse, used for both the phase and gap timing.

## Test plan
- **Single frame:** HALF_PERIOD=2, GAP_CYCLES=2, SYNC_STROBE=1. Send id=0x05, x=0x0123, y=0x0456, scale=0x02 → one strobe with `enqueue_en`=0, then bytes 05 01 23 04 56 02 on 6 rising `data_clk` edges. `frames_sent` becomes 1, and `in_ready` returns 31 cycles after accept.
- **Loopback:** connect to the sprite queue (initial size 2) and send 3 records → the queue size reaches 5, and dequeues return the sent id/x/y/scale values in order.
- **Input stability:** change the `sprite_*` inputs every cycle after accept → the transmitted bytes equal the values present on the accept cycle.
- **Back-to-back:** `in_valid` held high with 4 records → accepts are spaced exactly 31 cycles apart and `frames_sent`=4.
- **Reset mid-frame:** assert `reset` during byte 3 → next cycle all outputs are 0 and `frames_sent`=0. The following frame into the loopback queue is captured intact.
- **SYNC_STROBE=0, GAP_CYCLES=0:** frame takes 24 cycles and `in_ready` reasserts at T+25. Exactly 6 `data_clk` rising edges occur.
